// File: rtl/sm4_ck_seq.sv
// SM4 CK parameter sequencer: streams CK_i words (byte j = 28*i + 7*j mod 256)
// in forward or reverse order, LANES words per beat, over valid/ready.
module sm4_ck_seq #(
    parameter int ROUNDS = 32,
    parameter int LANES  = 1
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys,
    input  logic                  start,
    input  logic                  dec_mode,
    input  logic                  abort,
    output logic                  busy,
    output logic                  ck_valid,
    input  logic                  ck_ready,
    output logic [32*LANES-1:0]   ck_data,
    output logic [4:0]            ck_index,
    output logic                  ck_last
);

    localparam logic [4:0] IDX_REV0 = 5'(ROUNDS - 1);
    localparam logic [4:0] LAST_FWD = 5'(ROUNDS - LANES);
    localparam logic [4:0] LAST_REV = 5'(LANES - 1);
    localparam logic [4:0] IDX_STEP = 5'(LANES);
    localparam logic [7:0] BASE_REV = 8'((28 * (ROUNDS - 1)) % 256);
    localparam logic [7:0] BASE_STEP = 8'((28 * LANES) % 256);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t               r_state;
    logic                 r_dec;
    logic [4:0]           r_idx;
    logic [7:0]           r_base;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_last;
    logic [32*LANES-1:0]  r_data;

    logic [4:0]           w_idx_nxt;
    logic [7:0]           w_base_nxt;
    logic                 w_last_nxt;

    // Lane words derived from byte0 of lane 0 by wrap-around additions only.
    function automatic logic [32*LANES-1:0] f_build(input logic [7:0] base, input logic dec);
        logic [7:0]          lb;
        logic [32*LANES-1:0] d;
        d  = '0;
        lb = base;
        for (int k = 0; k < LANES; k++) begin
            d[32*k +: 32] = {lb, lb + 8'd7, lb + 8'd14, lb + 8'd21};
            lb = dec ? lb - 8'd28 : lb + 8'd28;
        end
        return d;
    endfunction

    assign w_idx_nxt  = r_dec ? r_idx - IDX_STEP : r_idx + IDX_STEP;
    assign w_base_nxt = r_dec ? r_base - BASE_STEP : r_base + BASE_STEP;
    assign w_last_nxt = (w_idx_nxt == (r_dec ? LAST_REV : LAST_FWD));

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_state <= S_IDLE;
            r_dec   <= 1'b0;
            r_idx   <= '0;
            r_base  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state <= S_RUN;
                        r_dec   <= dec_mode;
                        r_idx   <= dec_mode ? IDX_REV0 : 5'd0;
                        r_base  <= dec_mode ? BASE_REV : 8'd0;
                        r_data  <= f_build(dec_mode ? BASE_REV : 8'd0, dec_mode);
                        r_last  <= (ROUNDS == LANES);
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort || (ck_ready && r_last)) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_last  <= 1'b0;
                    end else if (ck_ready) begin
                        r_idx  <= w_idx_nxt;
                        r_base <= w_base_nxt;
                        r_data <= f_build(w_base_nxt, r_dec);
                        r_last <= w_last_nxt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign ck_valid = r_valid;
    assign ck_data  = r_data;
    assign ck_index = r_idx;
    assign ck_last  = r_last;

endmodule

// File: tb/tb_sm4_ck_seq.sv
// Directed bench for sm4_ck_seq: LANES=1 and LANES=4 instances on one clock.
module tb_sm4_ck_seq;

    logic         clk_sys = 1'b0;
    logic         rst_sys;
    logic         start, dec_mode, abort, ck_ready;
    logic         busy, ck_valid, ck_last;
    logic [31:0]  ck_data;
    logic [4:0]   ck_index;
    logic         start4, dec4, abort4, ready4;
    logic         busy4, valid4, last4;
    logic [127:0] data4;
    logic [4:0]   index4;

    always #5 clk_sys = ~clk_sys;

    sm4_ck_seq #(.ROUNDS(32), .LANES(1)) u_dut1 (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .start(start), .dec_mode(dec_mode),
        .abort(abort), .busy(busy), .ck_valid(ck_valid), .ck_ready(ck_ready),
        .ck_data(ck_data), .ck_index(ck_index), .ck_last(ck_last));

    sm4_ck_seq #(.ROUNDS(32), .LANES(4)) u_dut4 (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .start(start4), .dec_mode(dec4),
        .abort(abort4), .busy(busy4), .ck_valid(valid4), .ck_ready(ready4),
        .ck_data(data4), .ck_index(index4), .ck_last(last4));

    typedef struct {
        bit          dec;
        int          beat;
        logic [31:0] data;
        logic [4:0]  index;
        logic        last;
    } vec_t;

    vec_t        tbl[6];
    logic [31:0] cap_d[64];
    logic [4:0]  cap_i[64];
    logic        cap_l[64];
    int          npass = 0;
    int          ntot  = 0;

    function automatic logic [31:0] ck_model(input int i);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'((28 * i + 7 * j) % 256);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Runs one LANES=1 stream; optional stall at a beat and a start pulse mid-run.
    task automatic run1(input logic dm, input int stall_at, input int stall_len,
                        input bit mid_start, output int nb);
        int cyc = 0;
        int stc = 0;
        nb = 0;
        dec_mode = dm; start = 1'b1; ck_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("first_beat_latency", 128'(ck_valid), 128'd1);
        while (ck_valid && cyc < 300) begin
            if (nb == stall_at && stc < stall_len) begin
                ck_ready = 1'b0;
                chk("stall_hold_data", 128'(ck_data), 128'(ck_model(3)));
                chk("stall_hold_index", 128'(ck_index), 128'd3);
                stc++;
            end else begin
                ck_ready = 1'b1;
                if (nb < 64) begin
                    cap_d[nb] = ck_data; cap_i[nb] = ck_index; cap_l[nb] = ck_last;
                end
                nb++;
            end
            if (mid_start && nb == 5) begin start = 1'b1; dec_mode = ~dm; end
            else start = 1'b0;
            tick();
            cyc++;
        end
        start = 1'b0; dec_mode = dm; ck_ready = 1'b1;
        if (cyc >= 300) chk("run_timeout", 128'(cyc), 128'd0);
        chk("end_valid", 128'(ck_valid), 128'd0);
        chk("end_busy", 128'(busy), 128'd0);
    endtask

    task automatic check_tbl(input bit dm);
        foreach (tbl[n]) begin
            if (tbl[n].dec == dm) begin
                chk($sformatf("tbl%0d_data", n), 128'(cap_d[tbl[n].beat]), 128'(tbl[n].data));
                chk($sformatf("tbl%0d_index", n), 128'(cap_i[tbl[n].beat]), 128'(tbl[n].index));
                chk($sformatf("tbl%0d_last", n), 128'(cap_l[tbl[n].beat]), 128'(tbl[n].last));
            end
        end
    endtask

    task automatic check_all(input bit dm, input string tag);
        int bad = 0;
        for (int b = 0; b < 32; b++) begin
            int i = dm ? 31 - b : b;
            if (cap_d[b] !== ck_model(i) || cap_i[b] !== 5'(i) || cap_l[b] !== (b == 31)) bad++;
        end
        chk({tag, "_stream"}, 128'(bad), 128'd0);
    endtask

    initial begin
        int nb;
        tbl[0] = '{0, 0,  32'h00070e15, 5'd0,  1'b0};
        tbl[1] = '{0, 9,  32'hfc030a11, 5'd9,  1'b0};
        tbl[2] = '{0, 18, 32'hf8ff060d, 5'd18, 1'b0};
        tbl[3] = '{0, 31, 32'h646b7279, 5'd31, 1'b1};
        tbl[4] = '{1, 0,  32'h646b7279, 5'd31, 1'b0};
        tbl[5] = '{1, 31, 32'h00070e15, 5'd0,  1'b1};

        rst_sys = 1'b1; start = 0; dec_mode = 0; abort = 0; ck_ready = 1;
        start4 = 0; dec4 = 0; abort4 = 0; ready4 = 1;
        tick(); tick();
        chk("rst_valid", 128'(ck_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_last", 128'(ck_last), 128'd0);
        chk("rst_data", 128'(ck_data), 128'd0);
        chk("rst_index", 128'(ck_index), 128'd0);
        rst_sys = 1'b0;
        tick();

        run1(1'b0, -1, 0, 1'b0, nb);
        chk("fwd_beats", 128'(nb), 128'd32);
        check_tbl(1'b0);
        check_all(1'b0, "fwd");

        run1(1'b1, -1, 0, 1'b0, nb);
        chk("rev_beats", 128'(nb), 128'd32);
        check_tbl(1'b1);
        check_all(1'b1, "rev");

        // Stall 5 cycles on beat 3, plus a start pulse (with flipped mode) mid-run.
        run1(1'b0, 3, 5, 1'b1, nb);
        chk("bp_beats", 128'(nb), 128'd32);
        check_all(1'b0, "bp");

        // LANES=4 forward
        begin
            int c = 0;
            int n4 = 0;
            logic [127:0] b0 = '0, b7 = '0;
            logic [4:0] i0 = 5'd1, i7 = 5'd0;
            logic l0 = 1'b1, l7 = 1'b0;
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            while (valid4 && c < 100) begin
                if (n4 == 0) begin b0 = data4; i0 = index4; l0 = last4; end
                if (n4 == 7) begin b7 = data4; i7 = index4; l7 = last4; end
                n4++;
                tick();
                c++;
            end
            chk("l4_beats", 128'(n4), 128'd8);
            chk("l4_b0_data", b0, 128'h545b6269_383f464d_1c232a31_00070e15);
            chk("l4_b0_index", 128'(i0), 128'd0);
            chk("l4_b0_last", 128'(l0), 128'd0);
            chk("l4_b7_lane0", 128'(b7[31:0]), 128'h10171e25);
            chk("l4_b7_lane3", 128'(b7[127:96]), 128'h646b7279);
            chk("l4_b7_index", 128'(i7), 128'd28);
            chk("l4_b7_last", 128'(l7), 128'd1);
            chk("l4_end_busy", 128'(busy4), 128'd0);
        end

        // start+abort together in IDLE: no run
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_valid", 128'(ck_valid), 128'd0);
        chk("idle_abort_busy", 128'(busy), 128'd0);

        // Abort after beat 10 accepted
        dec_mode = 1'b0; start = 1'b1; ck_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        chk("pre_abort_index", 128'(ck_index), 128'd11);
        abort = 1'b1; ck_ready = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_valid", 128'(ck_valid), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        start = 1'b1; ck_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_valid", 128'(ck_valid), 128'd1);
        chk("restart_data", 128'(ck_data), 128'h00070e15);
        chk("restart_index", 128'(ck_index), 128'd0);

        // Reset mid-run
        repeat (6) tick();
        rst_sys = 1'b1;
        tick();
        chk("midrst_valid", 128'(ck_valid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_data", 128'(ck_data), 128'd0);
        chk("midrst_index", 128'(ck_index), 128'd0);
        chk("midrst_last", 128'(ck_last), 128'd0);
        rst_sys = 1'b0;
        tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/sm4_ck_seq.md
Name: sm4_ck_seq

Overview:
- Parametrised SM4 system-parameter (CK) sequencer for the key-expansion datapath.
- Computes CK_i arithmetically instead of from a fixed lookup table: byte j of CK_i = (28*i + 7*j) mod 256, j=0 is the MSB byte.
- Streams CK values in forward order (encrypt) or reverse order (decrypt), 1/2/4 lanes per beat, over a valid/ready handshake.
- Lets the key-expansion engine be unrolled and back-pressured.

Parameters:
- ROUNDS, 32, number of CK words per run; 1..32; must be a multiple of LANES.
- LANES, 1, CK words per output beat; legal values 1, 2, 4.

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- rst_sys  in  1  synchronous active-high reset
- start  in  1  single-cycle request to begin a run; sampled only in IDLE
- dec_mode  in  1  order select, latched on accepted start: 0 = forward, 1 = reverse
- abort  in  1  terminate the current run
- busy  out  1  high from the cycle after an accepted start until the run ends
- ck_valid  out  1  ck_data/ck_index/ck_last are valid
- ck_ready  in  1  consumer accepts the beat when ck_valid & ck_ready
- ck_data  out  32*LANES  lane k at bits [32k+31:32k]
- ck_index  out  5  round index carried by lane 0
- ck_last  out  1  marks the final beat of a run

Behaviour:
- Reset: rst_sys=1 forces IDLE; busy, ck_valid, ck_last, ck_data and ck_index all go to 0 on the next edge. Reset dominates every other input, including mid-run.
- States:
  - IDLE: ck_valid=0, busy=0. start=1 latches dec_mode, loads idx (0 when forward, ROUNDS-1 when reverse), then moves to RUN.
  - RUN: ck_valid=1, busy=1.
- Latency: the first beat is valid in the cycle after start is sampled.
- Lane contents, index idx:
  - forward: lane k = CK_(idx+k)
  - reverse: lane k = CK_(idx-k)
  - ck_index = idx
- Beat transfer on ck_valid & ck_ready:
  - idx advances by +LANES (forward) or -LANES (reverse).
  - After ROUNDS/LANES beats the run ends.
- ck_last=1 only on the final beat (forward idx = ROUNDS-LANES; reverse idx = LANES-1).
- Final beat accepted: next cycle IDLE, ck_valid=0, busy=0. A start arriving in the same cycle as final acceptance is ignored, because start is sampled only in IDLE.
- Backpressure: while ck_valid & !ck_ready, ck_data, ck_index and ck_last hold stable. The stall length is unbounded.
- start while busy: ignored, no restart and no effect on the latched mode.
- dec_mode changes after start: no effect on the run in progress.
- abort=1 in RUN: next cycle IDLE, ck_valid=0. A beat accepted in the abort cycle counts as consumed, but no further beats follow. abort in IDLE has no effect; if start=1 and abort=1 in IDLE, abort wins and no run starts.
- Arithmetic:
  - Byte values come from 8-bit wrap-around accumulators: +28 per index step, +7 per byte position.
  - No multipliers; mod 256 is implicit.
- ck_data is registered; no combinational path from ck_ready to ck_data.

Test Plan:
- LANES=1, dec_mode=0, ck_ready=1, pulse start -> 32 consecutive beats one cycle after start:
  - beat0 00070e15
  - beat9 fc030a11 (wrap check)
  - beat18 f8ff060d
  - beat31 646b7279 with ck_last=1
  - then ck_valid=0, busy=0
- LANES=1, dec_mode=1 -> beat0 646b7279 with ck_index=31; beat31 00070e15 with ck_index=0 and ck_last=1.
- LANES=4, forward, ck_ready=1 -> 8 beats:
  - beat0 ck_data = {1c232a31-lane3? no: lane3=545b6269, lane2=383f464d, lane1=1c232a31, lane0=00070e15}, ck_index=0
  - beat7 lane0=10171e25, lane3=646b7279, ck_last=1
- Backpressure: forward run, ck_ready low for 5 cycles at beat 3 -> ck_data holds 545b6269 throughout, no beat is skipped or duplicated, total accepted beats = 32. Additionally, pulse start mid-run -> ignored.
- Abort and reset:
  - abort asserted after beat 10 accepted -> ck_valid=0 next cycle; a new start then restarts at 00070e15.
  - Separate run: rst_sys asserted mid-run -> all outputs 0 next cycle.
